// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_ctrl
// Purpose  : EX-stage issue/commit controller for the multi-cycle mult/div
//            unit; owns the architectural HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int FUNCT_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      ex_valid,
    input  logic                      ex_md_req,
    input  logic                      ex_md_wr_hilo,
    input  logic [FUNCT_WIDTH-1:0]    ex_funct,
    input  logic [DATA_WIDTH-1:0]     ex_operand_1,
    input  logic [DATA_WIDTH-1:0]     ex_operand_2,
    input  logic                      mthi_wen,
    input  logic                      mtlo_wen,
    input  logic [DATA_WIDTH-1:0]     mt_data,
    output logic [FUNCT_WIDTH-1:0]    md_funct,
    output logic [DATA_WIDTH-1:0]     md_operand_1,
    output logic [DATA_WIDTH-1:0]     md_operand_2,
    output logic [DATA_WIDTH-1:0]     md_hi,
    output logic [DATA_WIDTH-1:0]     md_lo,
    output logic                      md_flush,
    input  logic                      md_done,
    input  logic [2*DATA_WIDTH-1:0]   md_result,
    output logic                      stall_req,
    output logic [DATA_WIDTH-1:0]     gpr_result,
    output logic [DATA_WIDTH-1:0]     hi,
    output logic [DATA_WIDTH-1:0]     lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      wr_hilo;
    logic [2*DATA_WIDTH-1:0]   result;
    logic                      issue;
    logic                      done_take;
    logic                      commit;

    assign issue     = (state == IDLE) & ex_valid & ex_md_req & ~flush;
    assign done_take = (state == BUSY) & md_done & ~flush;
    assign commit    = (state == DONE) & ~flush & wr_hilo;
    assign stall_req = issue | ((state == BUSY) & ~flush);
    assign md_flush  = flush;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (issue) state_next = BUSY;
                BUSY:    if (md_done) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_funct     <= '0;
            md_operand_1 <= '0;
            md_operand_2 <= '0;
            md_hi        <= '0;
            md_lo        <= '0;
            wr_hilo      <= 1'b0;
            result       <= '0;
            gpr_result   <= '0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            // Dropping md_funct to zero after done lets the unit clear its
            // done latch before the next operation can start.
            if (flush || done_take) begin
                md_funct <= '0;
            end else if (issue) begin
                md_funct <= ex_funct;
            end

            if (issue) begin
                md_operand_1 <= ex_operand_1;
                md_operand_2 <= ex_operand_2;
                md_hi        <= mthi_wen ? mt_data : hi;
                md_lo        <= mtlo_wen ? mt_data : lo;
                wr_hilo      <= ex_md_wr_hilo;
            end

            if (done_take) begin
                result     <= md_result;
                gpr_result <= md_result[DATA_WIDTH-1:0];
            end

            // The EX instruction is younger than the WB move, so its commit wins.
            if (commit) begin
                hi <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                lo <= result[DATA_WIDTH-1:0];
            end else begin
                if (mthi_wen) hi <= mt_data;
                if (mtlo_wen) lo <= mt_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_issue_ctrl
// Purpose  : Scoreboard bench for muldiv_issue_ctrl with an operation-level
//            HI/LO reference model and randomized operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue_ctrl;

    localparam int DW = 32;
    localparam int FW = 6;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          ex_valid;
    logic          ex_md_req;
    logic          ex_md_wr_hilo;
    logic [FW-1:0] ex_funct;
    logic [DW-1:0] ex_operand_1;
    logic [DW-1:0] ex_operand_2;
    logic          mthi_wen;
    logic          mtlo_wen;
    logic [DW-1:0] mt_data;
    logic [FW-1:0] md_funct;
    logic [DW-1:0] md_operand_1;
    logic [DW-1:0] md_operand_2;
    logic [DW-1:0] md_hi;
    logic [DW-1:0] md_lo;
    logic          md_flush;
    logic          md_done;
    logic [2*DW-1:0] md_result;
    logic          stall_req;
    logic [DW-1:0] gpr_result;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    muldiv_issue_ctrl #(.DATA_WIDTH(DW), .FUNCT_WIDTH(FW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_md_req(ex_md_req), .ex_md_wr_hilo(ex_md_wr_hilo),
        .ex_funct(ex_funct), .ex_operand_1(ex_operand_1), .ex_operand_2(ex_operand_2),
        .mthi_wen(mthi_wen), .mtlo_wen(mtlo_wen), .mt_data(mt_data),
        .md_funct(md_funct), .md_operand_1(md_operand_1), .md_operand_2(md_operand_2),
        .md_hi(md_hi), .md_lo(md_lo), .md_flush(md_flush),
        .md_done(md_done), .md_result(md_result), .stall_req(stall_req),
        .gpr_result(gpr_result), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] funct;
        logic [DW-1:0] op1, op2, snap_hi, snap_lo, gpr, hi, lo;
        bit            abort;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 0;
    logic [DW-1:0] ref_hi = '0;
    logic [DW-1:0] ref_lo = '0;
    logic [FW-1:0] functs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops an expectation whenever an operation leaves the unit.
    initial begin : monitor
        logic [FW-1:0] prev_f;
        bit            pend;
        logic [DW-1:0] ph, pl;
        exp_t          e;
        prev_f = '0;
        pend   = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!mon_en) begin
                prev_f = md_funct;
                pend   = 0;
            end else begin
                chk("md_flush", md_flush, flush);
                if (pend) begin
                    chk("commit_hi", hi, ph);
                    chk("commit_lo", lo, pl);
                    pend = 0;
                end
                if (prev_f != '0 && md_funct == '0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("abort_kind", flush, e.abort);
                        if (!flush) begin
                            chk("gpr_result", gpr_result, e.gpr);
                            chk("stall_in_done", stall_req, 0);
                        end
                        pend = 1;
                        ph   = e.hi;
                        pl   = e.lo;
                    end
                end else if (md_funct != '0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_busy", 1, 0);
                    end else begin
                        e = q[0];
                        chk("md_funct", md_funct, e.funct);
                        chk("md_operand_1", md_operand_1, e.op1);
                        chk("md_operand_2", md_operand_2, e.op2);
                        chk("md_hi", md_hi, e.snap_hi);
                        chk("md_lo", md_lo, e.snap_lo);
                        chk("stall_busy", stall_req, !flush);
                    end
                end
                prev_f = md_funct;
            end
        end
    end

    task automatic mt_write(input logic h, input logic l, input logic [DW-1:0] d);
        @(negedge clk);
        mthi_wen = h; mtlo_wen = l; mt_data = d;
        if (h) ref_hi = d;
        if (l) ref_lo = d;
        @(negedge clk);
        mthi_wen = 0; mtlo_wen = 0;
        chk("mt_hi", hi, ref_hi);
        chk("mt_lo", lo, ref_lo);
    endtask

    // One operation: unit reports done in BUSY cycle 'lat'; flush_at selects
    // a flush in BUSY cycle n (1..lat) or in DONE (lat+1); 0 means none.
    task automatic run_op(input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic wr, input logic [2*DW-1:0] res, input int lat, input int flush_at,
                          input logic mi, input logic [DW-1:0] mi_val,
                          input logic mdn, input logic [DW-1:0] md_val);
        exp_t e;
        int   stalls;
        bit   abort_busy, flush_done;
        abort_busy = (flush_at >= 1) && (flush_at <= lat);
        flush_done = (flush_at == lat + 1);
        e.funct   = f;
        e.op1     = a;
        e.op2     = b;
        e.snap_hi = mi ? mi_val : ref_hi;
        e.snap_lo = ref_lo;
        if (mi) ref_hi = mi_val;
        if (!abort_busy) begin
            if (wr && !flush_done) begin
                ref_hi = res[2*DW-1:DW];
                ref_lo = res[DW-1:0];
            end else if (mdn) begin
                ref_hi = md_val;
            end
        end
        e.hi    = ref_hi;
        e.lo    = ref_lo;
        e.gpr   = res[DW-1:0];
        e.abort = abort_busy;

        @(negedge clk);
        ex_valid = 1; ex_md_req = 1; ex_funct = f; ex_operand_1 = a; ex_operand_2 = b;
        ex_md_wr_hilo = wr; mthi_wen = mi; mt_data = mi_val;
        q.push_back(e);
        #1 stalls = int'(stall_req);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            mthi_wen      = 0;
            ex_funct      = FW'($urandom);
            ex_operand_1  = $urandom;
            ex_operand_2  = $urandom;
            ex_md_wr_hilo = 1'($urandom);
            md_done       = (c == lat);
            md_result     = (c == lat) ? res : {$urandom, $urandom};
            flush         = (c == flush_at);
            #1 stalls += int'(stall_req);
            if (c == flush_at) break;
        end
        if (!abort_busy) begin
            @(negedge clk);
            md_done = 0; md_result = {$urandom, $urandom};
            flush = flush_done; mthi_wen = mdn; mt_data = md_val;
            #1 stalls += int'(stall_req);
        end
        @(negedge clk);
        ex_valid = 0; ex_md_req = 0; md_done = 0; flush = 0; mthi_wen = 0;
        chk("stall_cycles", stalls, 1 + (abort_busy ? flush_at - 1 : lat));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [FW-1:0] f;
        int            lat, fa;
        functs = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h02, 6'h01, 6'h04};
        rst = 1; flush = 0; ex_valid = 0; ex_md_req = 0; ex_md_wr_hilo = 0;
        ex_funct = '0; ex_operand_1 = '0; ex_operand_2 = '0;
        mthi_wen = 0; mtlo_wen = 0; mt_data = '0; md_done = 0; md_result = '0;
        repeat (2) @(negedge clk);
        chk("rst_md_funct", md_funct, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_gpr", gpr_result, 0);
        chk("rst_stall", stall_req, 0);
        rst = 0;
        mon_en = 1;

        mt_write(1, 0, 32'hAAAA_AAAA);
        mt_write(0, 1, 32'h5555_5555);
        // MUL: low word to GPR, HI/LO untouched
        run_op(6'h02, 32'd7, 32'd6, 0, 64'd42, 3, 0, 0, '0, 0, '0);
        // MULTU with stall of three cycles
        run_op(6'h19, 32'h0001_0000, 32'h0001_0000, 1, 64'h1_0000_0000, 2, 0, 0, '0, 0, '0);
        // DIV killed by flush in BUSY cycle 9
        run_op(6'h1A, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 17, 9, 0, '0, 0, '0);
        // back-to-back MULT then DIVU
        run_op(6'h18, 32'hFFFF_FFFE, 32'd3, 1, 64'hFFFF_FFFF_FFFF_FFFA, 4, 0, 0, '0, 0, '0);
        run_op(6'h1B, 32'd50, 32'd8, 1, {32'd2, 32'd6}, 5, 0, 0, '0, 0, '0);
        // MADD snapshot with bypassed MTHI, then MTHI losing to the DONE commit
        run_op(6'h01, 32'd3, 32'd4, 1, 64'hDEAD_BEEF_0BAD_F00D, 3, 0, 1, 32'h1234, 1, 32'hFFFF);
        // done in the first BUSY cycle
        run_op(6'h19, 32'd9, 32'd9, 1, 64'd81, 1, 0, 0, '0, 0, '0);
        // flush together with md_done, then flush in DONE
        run_op(6'h18, 32'd5, 32'd5, 1, 64'h1111_2222_3333_4444, 3, 3, 0, '0, 0, '0);
        run_op(6'h18, 32'd6, 32'd5, 1, 64'h5555_6666_7777_8888, 2, 3, 0, '0, 1, 32'h0BEE);

        for (int i = 0; i < 40; i++) begin
            f   = functs[$urandom_range(0, 6)];
            lat = $urandom_range(1, 6);
            fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat + 1) : 0;
            run_op(f, $urandom, $urandom, 1'($urandom), {$urandom, $urandom}, lat, fa,
                   ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        // asynchronous reset in the middle of BUSY
        mt_write(1, 1, 32'hC0FF_EE11);
        mon_en = 0;
        @(negedge clk);
        ex_valid = 1; ex_md_req = 1; ex_funct = 6'h1A; ex_md_wr_hilo = 1;
        ex_operand_1 = 32'h1357_9BDF; ex_operand_2 = 32'h2468_ACE0;
        @(negedge clk);
        ex_valid = 0; ex_md_req = 0;
        #2 rst = 1;
        #1;
        chk("arst_md_funct", md_funct, 0);
        chk("arst_op1", md_operand_1, 0);
        chk("arst_op2", md_operand_2, 0);
        chk("arst_md_hi", md_hi, 0);
        chk("arst_md_lo", md_lo, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_stall", stall_req, 0);
        #1 rst = 0;
        @(negedge clk);
        md_done = 1; md_result = 64'h9999_8888_7777_6666;
        @(negedge clk);
        md_done = 0;
        repeat (2) @(negedge clk);
        chk("arst_no_commit_hi", hi, 0);
        chk("arst_no_commit_lo", lo, 0);
        chk("arst_gpr", gpr_result, 0);
        chk("arst_idle_funct", md_funct, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
